// File: rtl/gpio_serial_cfg_ctrl.sv
// Per-pad GPIO config register file plus a dual-chain serial shifter that latches all pads at once.
// Optional build macro GPIO_SERIAL_CFG_AUTOLOAD_EN: self-start one transfer of the reset words after reset.
module gpio_serial_cfg_ctrl #(
   parameter int               NUM_IO      = 38,
   parameter int               CFG_W       = 13,
   parameter int               CLK_DIV     = 2,
   parameter logic [CFG_W-1:0] CFG_DEFAULT = 13'h0403
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             cfg_we,
   input  logic [5:0]       cfg_addr,
   input  logic [CFG_W-1:0] cfg_wdata,
   output logic [CFG_W-1:0] cfg_rdata,
   output logic             wr_err,
   input  logic             xfer,
   output logic             busy,
   output logic             done,
   output logic             serial_clock,
   output logic             serial_load,
   output logic             serial_data_1,
   output logic             serial_data_2
);

   localparam int NUM_LO = NUM_IO / 2;
   localparam int IW     = $clog2(NUM_IO);
   localparam int WW     = $clog2(NUM_LO + 1);
   localparam int BW     = $clog2(CFG_W + 1);
   localparam int DW     = $clog2(CLK_DIV + 1);
   localparam logic [6:0] NUM_IO_W = 7'(NUM_IO);

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, FINISH} state_t;

   logic [CFG_W-1:0] cfg_q [NUM_IO];
   state_t           state_q;
   logic [WW-1:0]    word_q;
   logic [BW-1:0]    bit_q;
   logic [DW-1:0]    div_q;
   logic             busy_q, done_q, wr_err_q, sclk_q, sload_q, sd1_q, sd2_q;

   logic          addr_ok, idle_st, wr_ok, start, auto_go, last_bit, div_end;
   logic [IW-1:0] idx, lo_idx, hi_idx;
   logic [WW-1:0] word_d;
   logic [BW-1:0] bit_d;
   logic          nxt_d1, nxt_d2, st_d1, st_d2;

   assign addr_ok   = ({1'b0, cfg_addr} < NUM_IO_W);
   assign idx       = cfg_addr[IW-1:0];
   assign cfg_rdata = addr_ok ? cfg_q[idx] : '0;
   assign idle_st   = (state_q == IDLE) || (state_q == FINISH);
   assign wr_ok     = cfg_we && addr_ok && idle_st;

`ifdef GPIO_SERIAL_CFG_AUTOLOAD_EN
   logic [1:0] auto_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         auto_q <= 2'd0;
      end else if (auto_q != 2'd2) begin
         auto_q <= auto_q + 2'd1;
      end
   end

   // Fires on the second edge after reset release, exactly once.
   assign auto_go = (auto_q == 2'd1);
`else
   assign auto_go = 1'b0;
`endif

   assign start    = idle_st && (xfer || auto_go);
   assign last_bit = (word_q == WW'(NUM_LO - 1)) && (bit_q == '0);
   assign div_end  = (div_q == DW'(CLK_DIV - 1));

   // The first bit is fetched on the start edge, so forward a write landing on that same edge.
   assign st_d1 = (wr_ok && idx == IW'(NUM_LO - 1)) ? cfg_wdata[CFG_W-1] : cfg_q[NUM_LO-1][CFG_W-1];
   assign st_d2 = (wr_ok && idx == IW'(NUM_LO))     ? cfg_wdata[CFG_W-1] : cfg_q[NUM_LO][CFG_W-1];

   always_comb begin
      word_d = word_q;
      bit_d  = bit_q - BW'(1);
      if (bit_q == '0) begin
         word_d = word_q + WW'(1);
         bit_d  = BW'(CFG_W - 1);
      end
      lo_idx = IW'(NUM_LO - 1) - IW'(word_d);
      hi_idx = IW'(NUM_LO) + IW'(word_d);
      nxt_d1 = cfg_q[lo_idx][bit_d];
      nxt_d2 = cfg_q[hi_idx][bit_d];
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < NUM_IO; i++) cfg_q[i] <= CFG_DEFAULT;
      end else if (wr_ok) begin
         cfg_q[idx] <= cfg_wdata;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q  <= IDLE;
         word_q   <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
         sclk_q   <= 1'b0;
         sload_q  <= 1'b0;
         sd1_q    <= 1'b0;
         sd2_q    <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         wr_err_q <= cfg_we && !wr_ok;
         div_q    <= div_q + DW'(1);
         case (state_q)
            IDLE, FINISH: begin
               state_q <= IDLE;
               if (start) begin
                  state_q <= SHIFT_LO;
                  busy_q  <= 1'b1;
                  word_q  <= '0;
                  bit_q   <= BW'(CFG_W - 1);
                  div_q   <= '0;
                  sclk_q  <= 1'b0;
                  sd1_q   <= st_d1;
                  sd2_q   <= st_d2;
               end
            end
            SHIFT_LO: begin
               if (div_end) begin
                  div_q   <= '0;
                  state_q <= SHIFT_HI;
                  sclk_q  <= 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  div_q  <= '0;
                  sclk_q <= 1'b0;
                  if (last_bit) begin
                     state_q <= LOAD;
                     sload_q <= 1'b1;
                     sd1_q   <= 1'b0;
                     sd2_q   <= 1'b0;
                  end else begin
                     state_q <= SHIFT_LO;
                     word_q  <= word_d;
                     bit_q   <= bit_d;
                     sd1_q   <= nxt_d1;
                     sd2_q   <= nxt_d2;
                  end
               end
            end
            LOAD: begin
               if (div_end) begin
                  div_q   <= '0;
                  state_q <= FINISH;
                  sload_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign wr_err        = wr_err_q;
   assign serial_clock  = sclk_q;
   assign serial_load   = sload_q;
   assign serial_data_1 = sd1_q;
   assign serial_data_2 = sd2_q;

endmodule

// File: tb/tb_gpio_serial_cfg_ctrl.sv
// Scoreboard bench for gpio_serial_cfg_ctrl: stimulus queues expected transfers and wr_err
// events, a negedge monitor captures both chains and checks them when done or wr_err appears.
module tb_gpio_serial_cfg_ctrl;

   localparam int NB = 247;

   logic        clock = 1'b0;
   logic        resetb = 1'b0;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [12:0] cfg_wdata = '0;
   logic [12:0] cfg_rdata;
   logic        wr_err, xfer = 1'b0, busy, done;
   logic        serial_clock, serial_load, serial_data_1, serial_data_2;

   gpio_serial_cfg_ctrl dut (
      .clock(clock), .resetb(resetb),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .wr_err(wr_err), .xfer(xfer), .busy(busy), .done(done),
      .serial_clock(serial_clock), .serial_load(serial_load),
      .serial_data_1(serial_data_1), .serial_data_2(serial_data_2)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [NB-1:0] c1;
      logic [NB-1:0] c2;
   } exp_t;

   exp_t exp_q[$];
   int   wr_q[$];
   int   errors = 0, checks = 0, cyc = 0;
   int   busy_cnt = 0, edge_cnt = 0, load_cnt = 0;
   logic sclk_prev = 1'b0, done_prev = 1'b0;
   logic [NB-1:0] cap1 = '0, cap2 = '0;
   logic [NB-1:0] def_pat, t2_c1, t2_c2;
   exp_t mon_e;
   int   mon_w;

   function automatic void check(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endfunction

   // Monitor: captures chain bits on serial_clock rising, checks on done / wr_err.
   initial forever begin
      @(negedge clock);
      if (!resetb) begin
         busy_cnt = 0; edge_cnt = 0; load_cnt = 0;
         cap1 = '0; cap2 = '0; sclk_prev = 1'b0; done_prev = 1'b0;
      end else begin
         cyc++;
         if (done_prev) check("done_width", NB'(done), NB'(0));
         if (busy) busy_cnt++;
         if (serial_load) load_cnt++;
         if (serial_clock && !sclk_prev) begin
            cap1 = {cap1[NB-2:0], serial_data_1};
            cap2 = {cap2[NB-2:0], serial_data_2};
            edge_cnt++;
         end
         sclk_prev = serial_clock;
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", NB'(1), NB'(0));
            end else begin
               mon_e = exp_q.pop_front();
               $display("transfer done: cycle=%0d busy=%0d edges=%0d load=%0d", cyc, busy_cnt, edge_cnt, load_cnt);
               check("busy_cycles", NB'(busy_cnt), NB'(990));
               check("sclk_edges", NB'(edge_cnt), NB'(247));
               check("load_cycles", NB'(load_cnt), NB'(2));
               check("busy_at_done", NB'(busy), NB'(0));
               check("chain1", cap1, mon_e.c1);
               check("chain2", cap2, mon_e.c2);
            end
            busy_cnt = 0; edge_cnt = 0; load_cnt = 0; cap1 = '0; cap2 = '0;
         end
         done_prev = done;
         if (wr_err) begin
            if (wr_q.size() == 0) begin
               check("unexpected_wr_err", NB'(1), NB'(0));
            end else begin
               mon_w = wr_q.pop_front();
               $display("wr_err pulse: cycle=%0d", cyc);
               check("wr_err_cycle", NB'(cyc), NB'(mon_w));
            end
         end
      end
   end

   task automatic do_xfer(input logic [NB-1:0] c1, input logic [NB-1:0] c2);
      exp_t r;
      r.c1 = c1;
      r.c2 = c2;
      @(posedge clock); #1;
      xfer = 1'b1;
      exp_q.push_back(r);
      @(posedge clock); #1;
      xfer = 1'b0;
   endtask

   task automatic push_exp(input logic [NB-1:0] c1, input logic [NB-1:0] c2);
      exp_t r;
      r.c1 = c1;
      r.c2 = c2;
      exp_q.push_back(r);
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [12:0] d, input bit expect_err);
      @(posedge clock); #1;
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      if (expect_err) wr_q.push_back(cyc + 2);
      @(posedge clock); #1;
      cfg_we = 1'b0;
   endtask

   task automatic rd_check(input string nm, input logic [5:0] a, input logic [12:0] expv);
      cfg_addr = a;
      #1;
      check(nm, NB'(cfg_rdata), NB'(expv));
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done !== 1'b1 && n < 1500);
      check("done_seen", NB'(done), NB'(1));
   endtask

   initial begin
      logic busy_seen;
      def_pat = {19{13'h0403}};
      t2_c1   = {{18{13'h0403}}, 13'h1FFF};
      t2_c2   = {{18{13'h0403}}, 13'h0001};

      // Reset values
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", NB'(busy), NB'(0));
      check("rst_done", NB'(done), NB'(0));
      check("rst_wr_err", NB'(wr_err), NB'(0));
      check("rst_sclk", NB'(serial_clock), NB'(0));
      check("rst_load", NB'(serial_load), NB'(0));
      check("rst_sd1", NB'(serial_data_1), NB'(0));
      check("rst_sd2", NB'(serial_data_2), NB'(0));
      rd_check("rst_word0", 6'd0, 13'h0403);
      @(negedge clock);
      resetb = 1'b1;

      // Default-word transfer
`ifdef GPIO_SERIAL_CFG_AUTOLOAD_EN
      push_exp(def_pat, def_pat);
`else
      do_xfer(def_pat, def_pat);
`endif
      wait_done();

      // Edge pads rewritten, then transfer; write and xfer while busy are dropped
      cfg_write(6'd0, 13'h1FFF, 1'b0);
      cfg_write(6'd37, 13'h0001, 1'b0);
      rd_check("rd_pad0", 6'd0, 13'h1FFF);
      rd_check("rd_pad37", 6'd37, 13'h0001);
      rd_check("rd_pad1", 6'd1, 13'h0403);
      do_xfer(t2_c1, t2_c2);
      repeat (100) @(posedge clock);
      #1;
      xfer = 1'b1;
      cfg_write(6'd5, 13'h0AAA, 1'b1);
      xfer = 1'b0;
      wait_done();
      rd_check("rd_pad5_after_busy_wr", 6'd5, 13'h0403);

      // Out-of-range write
      cfg_write(6'd40, 13'h1234, 1'b1);
      rd_check("rd_addr40", 6'd40, 13'h0000);
      rd_check("rd_pad0_kept", 6'd0, 13'h1FFF);
      rd_check("rd_pad37_kept", 6'd37, 13'h0001);

      // Abort mid-transfer with reset
      @(posedge clock); #1;
      xfer = 1'b1;
      @(posedge clock); #1;
      xfer = 1'b0;
      repeat (300) @(posedge clock);
      #2;
      resetb = 1'b0;
      #1;
      exp_q.delete();
      check("abort_busy", NB'(busy), NB'(0));
      check("abort_done", NB'(done), NB'(0));
      check("abort_wr_err", NB'(wr_err), NB'(0));
      check("abort_sclk", NB'(serial_clock), NB'(0));
      check("abort_load", NB'(serial_load), NB'(0));
      check("abort_sd1", NB'(serial_data_1), NB'(0));
      check("abort_sd2", NB'(serial_data_2), NB'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("abort_no_load", NB'(serial_load), NB'(0));
      end
      rd_check("abort_word0_default", 6'd0, 13'h0403);
      @(negedge clock);
      resetb = 1'b1;

`ifdef GPIO_SERIAL_CFG_AUTOLOAD_EN
      push_exp(def_pat, def_pat);
      @(posedge clock); #1;
      check("auto_busy_edge1", NB'(busy), NB'(0));
      @(posedge clock); #1;
      check("auto_busy_edge2", NB'(busy), NB'(1));
`else
      busy_seen = 1'b0;
      repeat (2000) begin
         @(negedge clock);
         if (busy) busy_seen = 1'b1;
      end
      check("idle_2000_no_busy", NB'(busy_seen), NB'(0));
      do_xfer(def_pat, def_pat);
`endif
      wait_done();

      // xfer in the done cycle starts the next transfer
      xfer = 1'b1;
      push_exp(def_pat, def_pat);
      @(posedge clock); #1;
      xfer = 1'b0;
      check("b2b_busy", NB'(busy), NB'(1));
      wait_done();

      repeat (5) @(posedge clock);
      #1;
      check("exp_q_empty", NB'(exp_q.size()), NB'(0));
      check("wr_q_empty", NB'(wr_q.size()), NB'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_serial_cfg_ctrl.md
Name: gpio_serial_cfg_ctrl

Overview:
Sequencer that loads per-pad configuration words into the two serial shift chains feeding the mprj_io GPIO control blocks.
- Holds one CFG_W-bit config word per pad in a register file written by the management bus.
- On request, shifts both chains in parallel and then pulses serial_load so every pad adopts its new mode at the same time.
- Sits between the housekeeping/management register space and the pad control-block chain.

Parameters:
NUM_IO, 38, number of user GPIO pads; must be even; NUM_LO = NUM_IO/2 pads per chain
CFG_W, 13, config bits per pad
CLK_DIV, 2, system clocks per serial_clock half-period; minimum 1
CFG_DEFAULT, 13'h0403, reset value of every config word

Ports:
clock  input  1  system clock
resetb  input  1  asynchronous active-low reset
cfg_we  input  1  config register write strobe
cfg_addr  input  6  pad index 0..NUM_IO-1
cfg_wdata  input  CFG_W  write data
cfg_rdata  output  CFG_W  combinational readback of word[cfg_addr]
wr_err  output  1  one-cycle pulse when a write is dropped
xfer  input  1  start-transfer request, sampled high on a clock edge
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
serial_clock  output  1  shift clock to both chains
serial_load  output  1  chain latch strobe
serial_data_1  output  1  chain 1 data (pads 0..NUM_LO-1)
serial_data_2  output  1  chain 2 data (pads NUM_LO..NUM_IO-1)

Behaviour:
- Reset (resetb low, asynchronous): all words = CFG_DEFAULT; busy, done, wr_err, serial_clock, serial_load, serial_data_1 and serial_data_2 = 0; FSM = IDLE. A reset asserted mid-transfer aborts it immediately. Chain contents are left undefined and no load pulse is issued.
- Writes: cfg_we in IDLE with cfg_addr < NUM_IO updates the word at the next edge. Writes with cfg_addr >= NUM_IO, or any write while busy, are dropped and wr_err pulses on the next cycle.
- Readback: cfg_rdata returns 0 for cfg_addr >= NUM_IO.
- FSM states: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO for the next bit | LOAD) -> FINISH -> IDLE.
- IDLE: xfer = 1 -> busy = 1 from the next cycle. xfer is ignored while busy.
- Bit counter: 0..NUM_LO*CFG_W-1.
- Chain 1 order: the word for pad NUM_LO-1 is shifted first, pad 0 last.
- Chain 2 order: the word for pad NUM_LO is shifted first, pad NUM_IO-1 last.
- Within each word, MSB is shifted first.
- SHIFT_LO: serial_clock = 0 for CLK_DIV cycles; data for the current bit is driven from the first cycle and held stable.
- SHIFT_HI: serial_clock = 1 for CLK_DIV cycles; data is unchanged (the chain samples on the rising edge).
- LOAD: entered after the last SHIFT_HI. serial_clock = 0, serial_load = 1 for CLK_DIV cycles, data = 0.
- FINISH: busy deasserts and done = 1 for exactly one cycle (done is coincident with the first busy-low cycle).
- Busy duration = 2*CLK_DIV*NUM_LO*CFG_W + CLK_DIV cycles. For defaults this is 990 cycles.
- xfer asserted in the same cycle as done is accepted and starts a new transfer.
- serial_* outputs are registered and glitch-free.

Optional Feature:
GPIO_SERIAL_CFG_AUTOLOAD_EN:
- Defined: the block self-starts one transfer of the CFG_DEFAULT words exactly 2 cycles after resetb deasserts, with no xfer required. A write that arrives during this auto transfer is dropped and wr_err pulses.
- Undefined: the block stays in IDLE after reset until xfer.

Test Plan:
- Reset, xfer pulse, defaults -> busy high for 990 cycles; 247 serial_clock rising edges; a 247-bit capture on each chain equals 19 repetitions of 13'h0403 MSB-first; serial_load high 2 cycles; done single pulse.
- Write pad 0 = 13'h1FFF and pad 37 = 13'h0001, then xfer -> last 13 bits of chain 1 = 1FFF; last 13 bits of chain 2 = 0001; other words default.
- cfg_we during busy (addr 5, data 13'h0AAA) -> wr_err pulse; cfg_rdata at addr 5 is still 13'h0403 after done.
- Write to addr 40 -> wr_err pulse, no state change; readback of addr 40 = 0.
- resetb low at cycle 300 of a transfer -> all outputs 0 immediately, no serial_load pulse; after release, a new xfer produces a full 990-cycle transfer.
- With GPIO_SERIAL_CFG_AUTOLOAD_EN: release reset -> busy rises 2 cycles later, followed by a default-pattern transfer and a done pulse. Without the macro: busy stays 0 for 2000 cycles.
